spi_arbiter: RTL and testbench
==============================

Name: spi_arbiter

Overview:
Round-robin arbiter and sequencer that shares one SPI master between N_REQ requesters. It picks one pending requester and loads its byte onto the master's data input. It then pulses the master's tx_start, waits for the master's rx_done, and returns the received byte to the granted requester with a one-cycle valid pulse. It sits between client blocks and the SPI master's tx_start / master_data_in / master_data_out / master_rx_done pins.

Parameters:
N_REQ, 4, number of requesters (2..16)
DATA_W, 8, SPI word width; must match the master
TIMEOUT, 256, max cycles in WAIT before abort (used only with SPI_ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
req  in  N_REQ  per-requester request level, held until that requester's resp_valid
req_data  in  N_REQ*DATA_W  per-requester tx byte, slice i = requester i
grant  out  N_REQ  one-hot, high from START through RESP for the served requester
resp_valid  out  N_REQ  one-cycle pulse to the served requester
resp_data  out  DATA_W  received byte, valid while any resp_valid is high, held afterwards
busy  out  1  high in every state except IDLE
spi_tx_start  out  1  one-cycle pulse to master tx_start
spi_wdata  out  DATA_W  to master_data_in, stable from START until RESP
spi_rdata  in  DATA_W  from master_data_out
spi_done  in  1  from master_rx_done
err  out  1  sticky timeout flag (tied 0 without SPI_ARB_TIMEOUT_EN)

Behaviour:
- Reset values: state=IDLE, grant=0, resp_valid=0, resp_data=0, busy=0, spi_tx_start=0, spi_wdata=0, err=0, rr pointer=0 (requester 0 has highest priority first).
- Reset mid-transaction: the arbiter drops everything and returns to IDLE next cycle. No response pulse is issued. The master is reset by the same system reset.
- All outputs are registered. The state machine is Moore with states IDLE, START, WAIT, RESP.
- IDLE:
  - If req!=0, select the first set bit scanning from ptr upward, wrapping modulo N_REQ.
  - Latch its index, set grant one-hot, latch req_data slice into spi_wdata, go to START.
  - If req==0, remain in IDLE.
- START: spi_tx_start=1 for exactly this cycle, then go to WAIT. Latency from the first sampled req to spi_tx_start is 1 cycle.
- WAIT:
  - Hold grant and spi_wdata.
  - On spi_done=1, capture spi_rdata into resp_data and go to RESP.
  - spi_done is ignored in every other state.
- RESP:
  - resp_valid[idx]=1 for one cycle.
  - Set ptr=(idx+1) mod N_REQ.
  - Clear grant, go to IDLE.
- Minimum spacing is one IDLE cycle between transactions, so back-to-back requests cost 4 cycles plus the master's transfer time.
- Arbitration is decided only in IDLE. req changes during START/WAIT/RESP do not affect the current transfer.
- Requester drops req mid-transaction: the transfer still completes and resp_valid is still pulsed to that requester.
- Simultaneous requests: served strictly in rotating order. A continuously requesting client waits at most N_REQ-1 transactions.
- Only one resp_valid bit is ever high, and only one grant bit is ever high.

Optional Feature:
SPI_ARB_TIMEOUT_EN
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT-1 without spi_done, the FSM goes to RESP with resp_data=all-ones and the normal single resp_valid pulse.
  - It also sets err=1. err stays 1 until reset.
  - ptr advances as normal.
- Not defined: there is no counter, WAIT waits indefinitely, and err is constant 0.

Decomposition:
- Package spi_ctrl_pkg holds:
  - the state enum (IDLE, START, WAIT, RESP);
  - the DATA_W default constant;
  - an index-width helper constant, clog2 of N_REQ.
- Sub-module rr_pick is natural: purely combinational. Inputs are req and ptr; outputs are a one-hot grant and the binary index, found by a rotating priority scan. It is reused by future bus arbiters.

Test Plan:
- Single request: req=4'b0010, req_data[1]=8'hAB, model returns 8'hB7 on spi_done 20 cycles after tx_start -> spi_wdata=8'hAB, grant=4'b0010, exactly one spi_tx_start pulse, resp_valid=4'b0010 with resp_data=8'hB7 one cycle after spi_done.
- Simultaneous requests: req=4'b1111 held, each client deasserts after its resp_valid -> service order 0,1,2,3, each with its own req_data byte (8'h10,8'h21,8'h32,8'h43) appearing on spi_wdata.
- Fairness: requesters 0 and 2 request continuously for 6 transactions -> grants alternate 0,2,0,2,0,2. Requester 0 never takes two consecutive grants.
- Drop mid-transfer: requester 3 deasserts req during WAIT -> transfer completes, resp_valid[3] still pulses once, FSM returns to IDLE with busy=0.
- Reset mid-WAIT: reset=1 for one cycle during WAIT -> next cycle grant=0, busy=0, no resp_valid. A new req=4'b0001 is then served from requester 0.
- With SPI_ARB_TIMEOUT_EN and TIMEOUT=16: spi_done never asserted -> 16 WAIT cycles, then resp_valid pulse with resp_data=8'hFF and err=1. err stays 1 through the next normal transfer.

Source files
------------

// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI arbiter/sequencer and related bus arbiters.
package spi_ctrl_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int N_REQ_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Width of a binary requester index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W_DEF = idx_w(N_REQ_DEF);

endpackage

// File: rtl/spi_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set request at or above ptr,
// wrapping modulo N. Produces both a one-hot grant and the binary index.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o
);

  // Scan from ptr upward; the first hit wins and masks all later hits.
  always_comb begin
    logic             found;
    logic [IDX_W-1:0] pos;
    // NOTE: every output and temporary gets a default first so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    found = 1'b0;
    pos   = '0;
    gnt_o = '0;
    idx_o = '0;
    for (int i = 0; i < N; i++) begin
      pos = IDX_W'((int'(ptr_i) + i) % N);
      if (!found && req_i[pos]) begin
        found      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = pos;
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter/sequencer sharing one SPI master between N_REQ clients.
// Moore FSM IDLE -> START -> WAIT -> RESP -> IDLE, all outputs registered.
// Optional macro SPI_ARB_TIMEOUT_EN: abort WAIT after TIMEOUT cycles with an
// all-ones response and a sticky err flag; without it WAIT never times out.
module spi_arbiter
  import spi_ctrl_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]       resp_data,
  output logic                    busy,
  output logic                    spi_tx_start,
  output logic [DATA_W-1:0]       spi_wdata,
  input  logic [DATA_W-1:0]       spi_rdata,
  input  logic                    spi_done,
  output logic                    err
);

  localparam int IDX_W = idx_w(N_REQ);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d, idx_q, idx_d, pick_idx;
  logic [N_REQ-1:0]    grant_q, grant_d, resp_valid_q, resp_valid_d, pick_gnt;
  logic [DATA_W-1:0]   wdata_q, wdata_d, resp_data_q, resp_data_d;
  logic                busy_q, busy_d, tx_start_q, tx_start_d;
  logic                timeout_hit;

  rr_pick #(.N(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  assign timeout_hit = (state_q == WAIT) && (cnt_q == CNT_W'(TIMEOUT - 1));

  // WAIT-cycle counter restarts on every WAIT entry; err latches on abort.
  always_comb begin
    cnt_d = (state_q == WAIT) ? cnt_q + 1'b1 : '0;
    err_d = err_q | (timeout_hit && !spi_done);
  end

  // Timeout counter and sticky error register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign timeout_hit    = 1'b0;
  assign err            = 1'b0;
`endif

  // State and registered-output storage with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      idx_q        <= '0;
      grant_q      <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      wdata_q      <= '0;
      busy_q       <= 1'b0;
      tx_start_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      idx_q        <= idx_d;
      grant_q      <= grant_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      wdata_q      <= wdata_d;
      busy_q       <= busy_d;
      tx_start_q   <= tx_start_d;
    end
  end

  // Next-state logic; arbitration only ever happens from IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|req) state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (spi_done || timeout_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the upcoming state.
  always_comb begin
    ptr_d        = ptr_q;
    idx_d        = idx_q;
    grant_d      = grant_q;
    wdata_d      = wdata_q;
    resp_data_d  = resp_data_q;
    resp_valid_d = '0;
    tx_start_d   = (state_d == START);
    busy_d       = (state_d != IDLE);
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          idx_d   = pick_idx;
          grant_d = pick_gnt;
          for (int i = 0; i < N_REQ; i++) begin
            if (pick_gnt[i]) wdata_d = req_data[i*DATA_W +: DATA_W];
          end
        end
      end
      WAIT: begin
        if (spi_done)         resp_data_d = spi_rdata;
        else if (timeout_hit) resp_data_d = '1;
        if (state_d == RESP)  resp_valid_d = grant_q;
      end
      RESP: begin
        ptr_d   = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
        grant_d = '0;
      end
      default: ;
    endcase
  end

  assign grant        = grant_q;
  assign resp_valid   = resp_valid_q;
  assign resp_data    = resp_data_q;
  assign busy         = busy_q;
  assign spi_tx_start = tx_start_q;
  assign spi_wdata    = wdata_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Self-checking bench for spi_arbiter: directed scenarios plus randomized
// traffic scored against a queue-free round-robin model (pointer arithmetic).
module tb_spi_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      grant, resp_valid;
  logic [DW-1:0]     resp_data, spi_wdata, spi_rdata;
  logic              busy, spi_tx_start, spi_done, err;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] bytes_m [N];
  int            ptr_m;

  spi_arbiter #(.N_REQ(N), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_data     (req_data),
    .grant        (grant),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .busy         (busy),
    .spi_tx_start (spi_tx_start),
    .spi_wdata    (spi_wdata),
    .spi_rdata    (spi_rdata),
    .spi_done     (spi_done),
    .err          (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load_bytes();
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = bytes_m[i];
  endtask

  task automatic apply_reset();
    reset = 1'b1; req = '0; spi_done = 1'b0;
    tick(); tick();
    reset = 1'b0;
    ptr_m = 0;
  endtask

  // Reference rule: first requester at or after the pointer, wrapping.
  function automatic int model_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (p + k) % N;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  // One complete transaction starting from IDLE with req already applied.
  task automatic do_txn(input int exp_idx, input logic [DW-1:0] rdata, input int delay,
                        input bit drop_in_wait, input bit release_after,
                        input logic [N-1:0] add_mask, output int lat);
    logic [N-1:0] exp_g;
    bit seen;
    int extra, hold_bad;
    exp_g = '0; exp_g[exp_idx] = 1'b1;
    seen = 1'b0; lat = 0; extra = 0; hold_bad = 0;
    while (!seen && lat < 8) begin
      tick(); lat++;
      if (spi_tx_start === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL txn_start idx=%0d: no spi_tx_start in 8 cycles", exp_idx);
      return;
    end
    checks++;
    if (grant !== exp_g) begin
      errors++; $display("FAIL grant: got %b want %b", grant, exp_g);
    end
    checks++;
    if (spi_wdata !== bytes_m[exp_idx]) begin
      errors++; $display("FAIL wdata idx=%0d: got %h want %h", exp_idx, spi_wdata, bytes_m[exp_idx]);
    end
    for (int k = 0; k < delay; k++) begin
      tick();
      if (k == 0) begin
        if (drop_in_wait) req[exp_idx] = 1'b0;
        req = req | add_mask;
      end
      if (spi_tx_start !== 1'b0) extra++;
      if (grant !== exp_g || spi_wdata !== bytes_m[exp_idx] || busy !== 1'b1) hold_bad++;
    end
    checks++;
    if (extra != 0 || hold_bad != 0) begin
      errors++; $display("FAIL wait_hold: extra_starts=%0d hold_errors=%0d want 0/0", extra, hold_bad);
    end
    spi_rdata = rdata; spi_done = 1'b1;
    tick();
    spi_done = 1'b0; spi_rdata = DW'($urandom);
    checks++;
    if (resp_valid !== exp_g || resp_data !== rdata || grant !== exp_g) begin
      errors++;
      $display("FAIL resp: valid=%b data=%h grant=%b want valid=%b data=%h grant=%b",
               resp_valid, resp_data, grant, exp_g, rdata, exp_g);
    end
    if (release_after) req[exp_idx] = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || grant !== '0 || resp_valid !== '0 || resp_data !== rdata) begin
      errors++;
      $display("FAIL idle_after: busy=%b grant=%b valid=%b data=%h want 0/0/0/%h",
               busy, grant, resp_valid, resp_data, rdata);
    end
    ptr_m = (exp_idx + 1) % N;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '1; spi_done = 1'b1; spi_rdata = 8'h5A;
    for (int i = 0; i < N; i++) bytes_m[i] = DW'($urandom);
    load_bytes();
    tick(); tick();
    checks++;
    if (grant !== '0 || resp_valid !== '0 || resp_data !== '0 || busy !== 1'b0 ||
        spi_tx_start !== 1'b0 || spi_wdata !== '0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: grant=%b valid=%b rdata=%h busy=%b start=%b wdata=%h err=%b want all 0",
               grant, resp_valid, resp_data, busy, spi_tx_start, spi_wdata, err);
    end
    reset = 1'b0; req = '0; spi_done = 1'b0;
    ptr_m = 0;
    tick();
  endtask

  task automatic test_single();
    int lat;
    apply_reset();
    bytes_m[1] = 8'hAB; load_bytes();
    req = 4'b0010;
    do_txn(1, 8'hB7, 20, 1'b0, 1'b1, '0, lat);
    checks++;
    if (lat != 1) begin
      errors++; $display("FAIL start_latency: got %0d want 1", lat);
    end
  endtask

  task automatic test_simultaneous();
    int lat;
    apply_reset();
    bytes_m[0] = 8'h10; bytes_m[1] = 8'h21; bytes_m[2] = 8'h32; bytes_m[3] = 8'h43;
    load_bytes();
    req = 4'b1111;
    for (int i = 0; i < N; i++)
      do_txn(i, DW'($urandom), $urandom_range(1, 5), 1'b0, 1'b1, '0, lat);
  endtask

  task automatic test_fairness();
    int lat;
    apply_reset();
    req = 4'b0101;
    for (int t = 0; t < 6; t++) do_txn((t % 2) * 2, DW'($urandom), 3, 1'b0, 1'b0, '0, lat);
    req = '0;
    tick();
  endtask

  task automatic test_drop();
    int lat, bad;
    apply_reset();
    bytes_m[3] = DW'($urandom); load_bytes();
    req = 4'b1000;
    do_txn(3, 8'h3C, 6, 1'b1, 1'b0, '0, lat);
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (busy !== 1'b0 || spi_tx_start !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL drop_idle: %0d busy cycles after drop, want 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    apply_reset();
    req = 4'b0100;
    tick();
    checks++;
    if (spi_tx_start !== 1'b1) begin
      errors++; $display("FAIL reset_mid_start: start=%b want 1", spi_tx_start);
    end
    tick(); tick(); tick();
    reset = 1'b1; req = '0;
    tick();
    reset = 1'b0;
    checks++;
    if (grant !== '0 || busy !== 1'b0 || resp_valid !== '0) begin
      errors++; $display("FAIL reset_mid: grant=%b busy=%b valid=%b want 0/0/0", grant, busy, resp_valid);
    end
    ptr_m = 0;
    spi_done = 1'b1; spi_rdata = 8'hEE;
    tick();
    spi_done = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || resp_valid !== '0 || resp_data !== '0) begin
      errors++; $display("FAIL stray_done: busy=%b valid=%b data=%h want 0/0/00", busy, resp_valid, resp_data);
    end
    req = 4'b0001;
    do_txn(0, 8'h99, 2, 1'b0, 1'b1, '0, lat);
  endtask

  task automatic test_random();
    int lat, idx;
    for (int t = 0; t < 40; t++) begin
      if (req == '0) req = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) bytes_m[i] = DW'($urandom);
      load_bytes();
      idx = model_pick(req, ptr_m);
      do_txn(idx, DW'($urandom), $urandom_range(1, 6), ($urandom % 4) == 0, 1'b1,
             N'($urandom) & N'($urandom), lat);
      if ($urandom % 2) req = req | N'($urandom);
    end
    req = '0;
    tick();
  endtask

  task automatic test_err();
`ifdef SPI_ARB_TIMEOUT_EN
    int cnt, lat;
    apply_reset();
    bytes_m[1] = 8'h5A; load_bytes();
    req = 4'b0010;
    tick();
    cnt = 0;
    while (resp_valid === '0 && cnt < 60) begin
      tick(); cnt++;
    end
    checks++;
    if (cnt != TO + 1) begin
      errors++; $display("FAIL timeout_cycles: got %0d want %0d", cnt, TO + 1);
    end
    checks++;
    if (resp_valid !== 4'b0010 || resp_data !== 8'hFF || err !== 1'b1) begin
      errors++; $display("FAIL timeout_resp: valid=%b data=%h err=%b want 0010/ff/1", resp_valid, resp_data, err);
    end
    req = 4'b0001;
    do_txn(0, 8'h3C, 4, 1'b0, 1'b1, '0, lat);
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL err_sticky: got %b want 1", err);
    end
    apply_reset();
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL err_reset: got %b want 0", err);
    end
`else
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL err_tied: got %b want 0", err);
    end
`endif
  endtask

  initial begin
    reset = 1'b1; req = '0; req_data = '0; spi_rdata = '0; spi_done = 1'b0; ptr_m = 0;
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_drop();
    test_reset_mid();
    test_random();
    test_err();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
